// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an 8x8 activation matrix and an 8x8 weight matrix,
// then streams them into a systolic array with the diagonal skew applied.
// Row i of activations and column j of weights are each delayed by their
// lane index. A per-row done flag marks the step after that row's last data.
module systolic_feeder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         load_sel,
  input  logic [2:0]   load_row,
  input  logic [127:0] load_data,
  input  logic         start,
  output logic         busy,
  output logic         finish,
  output logic [127:0] activations,
  output logic [127:0] weights,
  output logic [7:0]   done
);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t       state, state_nxt;
  logic [3:0]   t, t_nxt;
  logic [15:0]  a_buf [8][8];
  logic [15:0]  w_buf [8][8];
  logic [127:0] act_nxt, wgt_nxt;
  logic [7:0]   done_nxt;
  logic         load_fire;

  assign load_ready = (state == IDLE) && en && !start;
  assign load_fire  = load_valid && load_ready;
  assign busy       = (state != IDLE);

  // Next-state and step-counter logic; the enable gate lives in the register.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          t_nxt     = '0;
        end
      end
      STREAM: begin
        if (t == 4'd15) begin
          state_nxt = FIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 4'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and step counter; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else if (en) begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  // Skewed lane selection for the current step: lane i reads element t-i.
  always_comb begin
    act_nxt  = '0;
    wgt_nxt  = '0;
    done_nxt = '0;
    if (state == STREAM) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if ((32'(t) >= i) && (32'(t) - i <= 32'd7)) begin
          act_nxt[16*i +: 16] = a_buf[3'(i)][3'(32'(t) - i)];
          wgt_nxt[16*i +: 16] = w_buf[3'(32'(t) - i)][3'(i)];
        end
        done_nxt[i] = (32'(t) == 32'd8 + i);
      end
    end
  end

  // Registered outputs; finish is registered from the FIN state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activations <= '0;
      weights     <= '0;
      done        <= '0;
      finish      <= 1'b0;
    end else if (en) begin
      activations <= act_nxt;
      weights     <= wgt_nxt;
      done        <= done_nxt;
      finish      <= (state == FIN);
    end
  end

  // Matrix buffers: one whole row written per accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 8; r++) begin
        for (int unsigned c = 0; c < 8; c++) begin
          a_buf[r][c] <= '0;
          w_buf[r][c] <= '0;
        end
      end
    end else if (load_fire) begin
      for (int unsigned c = 0; c < 8; c++) begin
        if (load_sel) w_buf[load_row][c] <= load_data[16*c +: 16];
        else          a_buf[load_row][c] <= load_data[16*c +: 16];
      end
    end
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  global enable; low freezes all state.
REQ-005 load_valid  input  1  load request; accepted when load_valid and load_ready are both high.
REQ-006 load_ready  output  1  high when a load can be accepted.
REQ-007 load_sel  input  1  load target: 0 selects the activation buffer A, 1 selects the weight buffer W.
REQ-008 load_row  input  3  row index written.
REQ-009 load_data  input  128  eight 16-bit lanes; lane k is bits [16k+15:16k] and holds element [load_row][k].
REQ-010 start  input  1  begin streaming the buffered matrices.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 finish  output  1  one-cycle pulse at the end of the stream.
REQ-013 activations  output  128  skewed activation lanes, one per array row, 16 bits each.
REQ-014 weights  output  128  skewed weight lanes, one per array column, 16 bits each.
REQ-015 done  output  8  per-row end-of-data flags driven to the array's done inputs.

Function
REQ-016 Buffers SHALL be A[8][8] and W[8][8], each element 16 bits; A[i][k] is activation row i, step k; W[k][j] is weight step k, column j.
REQ-017 load_ready SHALL equal (state==IDLE) && en && !start.
REQ-018 An accepted load SHALL write all 8 lanes of the selected row in the same clock edge.
REQ-019 The FSM SHALL have the states IDLE, STREAM and FIN.
REQ-020 In IDLE, start=1 with en=1 SHALL move the FSM to STREAM with step counter t=0.
REQ-021 In STREAM, t SHALL advance by 1 per enabled cycle from 0 to 15; at t=15 the FSM SHALL go to FIN.
REQ-022 FIN SHALL last one enabled cycle, assert finish=1, then return to IDLE.
REQ-023 If the start edge is cycle S, step t SHALL appear on the registered outputs in cycle S+1+t, and finish SHALL be high in cycle S+17 only.
REQ-024 At step t, activations lane i SHALL be A[i][t-i] when 0<=t-i<=7; otherwise it SHALL be 0.
REQ-025 At step t, weights lane j SHALL be W[t-j][j] when 0<=t-j<=7; otherwise it SHALL be 0.
REQ-026 At step t, done[i] SHALL be 1 only when t==8+i; done[7] is therefore set at step 15.
REQ-027 Outside STREAM, activations, weights and done SHALL be 0.
REQ-028 start SHALL be ignored in STREAM and FIN.
REQ-029 Buffers SHALL be unmodified by streaming and SHALL be reusable by a later start without reloading.
REQ-030 With en=0, the FSM, t, buffers and all outputs SHALL hold their values; no load SHALL be accepted and start SHALL be ignored.
REQ-031 No arithmetic SHALL be applied to the data; values SHALL pass through bit-exact.

Reset
REQ-032 While rst_n=0, the FSM SHALL be IDLE, t SHALL be 0, all A and W entries SHALL be 0, and activations, weights, done, finish and busy SHALL all be 0.
REQ-033 Reset asserted mid-stream SHALL abort the stream immediately with no finish pulse; after release the block SHALL be in IDLE with load_ready=1 whenever en=1 and start=0.

Verification
REQ-034 Reset: with rst_n=0 then released and en=1, start=0 -> all outputs are 0 and load_ready=1.
REQ-035 Skew: load A[i][k]=16*i+k and W[k][j]=256*k+j, then start at cycle S:
- cycle S+1: activations lane0=0x0000, weights lane0=0x0000.
- cycle S+2: activations lane1=0x0010, weights lane1=0x0001.
- cycle S+15: activations lane7=0x0077, weights lane7=0x0707.
- cycle S+16: done=8'h80 and all data lanes are 0.
- cycle S+17: finish=1.
REQ-036 Re-start: start held high through the stream -> only one finish pulse per pass; a second start in IDLE replays identical data.
REQ-037 Enable stall: en=0 for 3 cycles at step 5 -> the outputs hold step-5 values throughout, and finish moves to S+20.
REQ-038 Mid-stream reset: rst_n pulsed low at step 5 -> outputs go to 0 immediately, no finish pulse occurs, and a restart after reset streams all zeros.
REQ-039 Load blocking: load_valid=1 on the start cycle and during STREAM -> load_ready=0 and the buffer contents are unchanged.
